// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter slice.
package imem_pkg;

    localparam int IM_AW_DEF    = 8;
    localparam int IW_DEF       = 16;
    localparam int MAX_WAIT_DEF = 4;
    localparam int CNT_W        = 4;

    // Arbiter ownership mode
    typedef enum logic {
        NORMAL = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Which requester the in-flight read belongs to
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/imem_age_ctr.sv
// Saturating host wait counter; sat_flag tells the arbiter the host has waited long enough.
module imem_age_ctr
    import imem_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic sat_flag
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    // Clear wins over increment; counting stops at the saturation value
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != SAT_VAL)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign sat_flag = (wait_cnt == SAT_VAL);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port IMEM between CPU fetch and the host load/debug port.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int IM_AW    = IM_AW_DEF,
    parameter int IW       = IW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic [IM_AW-1:0] cpu_addr,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [IW-1:0]    cpu_rdata,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [IM_AW-1:0] host_addr,
    input  logic [IW-1:0]    host_wdata,
    output logic             host_gnt,
    output logic             host_rvalid,
    output logic [IW-1:0]    host_rdata,
    input  logic             host_lock,
    output logic             lock_ack,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IM_AW-1:0] mem_addr,
    output logic [IW-1:0]    mem_wdata,
    input  logic [IW-1:0]    mem_rdata
);

    arb_state_t    state;
    owner_t        owner;
    logic          age_sat;
    logic [IW-1:0] cpu_rdata_q;
    logic [IW-1:0] host_rdata_q;

    imem_age_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk      (clk),
        .rst      (rst),
        .clr      (host_gnt),
        .inc      (host_req && !host_gnt),
        .sat_flag (age_sat)
    );

    // Ownership FSM: host_lock moves us into exclusive host mode and back
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NORMAL;
            lock_ack <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (host_lock) begin
                        state    <= LOCKED;
                        lock_ack <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!host_lock) begin
                        state    <= NORMAL;
                        lock_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= NORMAL;
                    lock_ack <= 1'b0;
                end
            endcase
        end
    end

    // Grant selection: CPU first unless the host has aged out or owns the memory
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!rst) begin
            if (state == LOCKED) begin
                host_gnt = host_req;
            end else if (host_req && (!cpu_req || age_sat)) begin
                host_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
            end
        end
    end

    // Memory port driven from whichever side won this cycle
    always_comb begin
        mem_en    = cpu_gnt || host_gnt;
        mem_we    = host_we && host_gnt;
        mem_addr  = host_gnt ? host_addr : cpu_addr;
        mem_wdata = host_wdata;
    end

    // Tag the granted read and capture returned data so each side holds its last word
    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= OWN_NONE;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (cpu_gnt) begin
                owner <= OWN_CPU;
            end else if (host_gnt && !host_we) begin
                owner <= OWN_HOST;
            end else begin
                owner <= OWN_NONE;
            end
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (host_rvalid) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    // Return steering; a return that lands while rst is high is dropped
    always_comb begin
        cpu_rvalid  = (owner == OWN_CPU) && !rst;
        host_rvalid = (owner == OWN_HOST) && !rst;
        cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: table of cycle vectors plus a read-return scoreboard.
module tb_imem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [7:0]  cpu_addr;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [15:0] host_rdata;
    logic        host_lock;
    logic        lock_ack;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        preload;

    typedef struct {
        logic        rst;
        logic        cpu_req;
        logic [7:0]  cpu_addr;
        logic        host_req;
        logic        host_we;
        logic [7:0]  host_addr;
        logic [15:0] host_wdata;
        logic        host_lock;
        logic        exp_cgnt;
        logic        exp_hgnt;
        logic        exp_lock;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    vec_t        tbl[$];
    ret_t        cpu_q[$];
    ret_t        host_q[$];
    logic [15:0] gold [256];
    logic [15:0] imem [256];
    logic [15:0] cpu_last;
    logic [15:0] host_last;
    int          cyc;
    int          n_checks;
    int          n_miss;

    imem_arbiter #(
        .IM_AW    (8),
        .IW       (16),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .host_lock   (host_lock),
        .lock_ack    (lock_ack),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 16'h0123 + 16'h0A05);
    endfunction

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read IMEM macro model, preloaded once at start-up
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) imem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) imem[mem_addr] <= mem_wdata;
            else        mem_rdata <= imem[mem_addr];
        end
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic cr, input logic [7:0] ca,
                                input logic hr, input logic hw, input logic [7:0] ha,
                                input logic [15:0] hd, input logic hl,
                                input logic ecg, input logic ehg, input logic el);
        vec_t v;
        v.rst = r; v.cpu_req = cr; v.cpu_addr = ca; v.host_req = hr; v.host_we = hw;
        v.host_addr = ha; v.host_wdata = hd; v.host_lock = hl;
        v.exp_cgnt = ecg; v.exp_hgnt = ehg; v.exp_lock = el;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst        = v.rst;
        cpu_req    = v.cpu_req;
        cpu_addr   = v.cpu_addr;
        host_req   = v.host_req;
        host_we    = v.host_we;
        host_addr  = v.host_addr;
        host_wdata = v.host_wdata;
        host_lock  = v.host_lock;
        cyc++;
    endtask

    task automatic checkOutput(input vec_t v);
        logic exp_cv;
        logic exp_hv;
        @(negedge clk);
        if (v.rst) begin
            cpu_q.delete();
            host_q.delete();
        end
        compareVal("cpu_gnt", 32'(cpu_gnt), 32'(v.exp_cgnt));
        compareVal("host_gnt", 32'(host_gnt), 32'(v.exp_hgnt));
        compareVal("mem_en", 32'(mem_en), 32'(v.exp_cgnt | v.exp_hgnt));
        compareVal("mem_we", 32'(mem_we), 32'(v.exp_hgnt & v.host_we));
        if (v.exp_cgnt || v.exp_hgnt)
            compareVal("mem_addr", 32'(mem_addr), 32'(v.exp_hgnt ? v.host_addr : v.cpu_addr));
        if (!v.rst)
            compareVal("lock_ack", 32'(lock_ack), 32'(v.exp_lock));

        exp_cv = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
        compareVal("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
        if (exp_cv) begin
            cpu_last = cpu_q[0].data;
            void'(cpu_q.pop_front());
            compareVal("cpu_rdata", 32'(cpu_rdata), 32'(cpu_last));
        end else if (!v.rst) begin
            compareVal("cpu_rdata_hold", 32'(cpu_rdata), 32'(cpu_last));
        end

        exp_hv = (host_q.size() > 0) && (host_q[0].due == cyc);
        compareVal("host_rvalid", 32'(host_rvalid), 32'(exp_hv));
        if (exp_hv) begin
            host_last = host_q[0].data;
            void'(host_q.pop_front());
            compareVal("host_rdata", 32'(host_rdata), 32'(host_last));
        end else if (!v.rst) begin
            compareVal("host_rdata_hold", 32'(host_rdata), 32'(host_last));
        end

        if (v.rst) begin
            cpu_last  = '0;
            host_last = '0;
        end else begin
            if (v.exp_cgnt) cpu_q.push_back('{cyc + 1, gold[v.cpu_addr]});
            if (v.exp_hgnt) begin
                if (v.host_we) gold[v.host_addr] = v.host_wdata;
                else           host_q.push_back('{cyc + 1, gold[v.host_addr]});
            end
        end
    endtask

    // Main sequence: build the vector table, run it, then the hand-written aging check
    initial begin
        vec_t v;
        int   grant_at;
        n_checks = 0; n_miss = 0; cyc = 0;
        cpu_last = '0; host_last = '0;
        for (int i = 0; i < 256; i++) gold[i] = init_word(i);
        rst = 1'b1; preload = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0; host_lock = 1'b0;

        // Reset with both sides requesting: nothing may be granted
        add(mk(1, 1, 8'd0, 1, 0, 8'd0, 16'h0, 0, 0, 0, 0));
        add(mk(1, 1, 8'd0, 1, 0, 8'd0, 16'h0, 0, 0, 0, 0));
        // CPU-only streaming fetch
        for (int a = 0; a < 8; a++) add(mk(0, 1, 8'(a), 0, 0, 8'd0, 16'h0, 0, 1, 0, 0));
        add(mk(0, 0, 8'd0, 0, 0, 8'd0, 16'h0, 0, 0, 0, 0));
        // Host write then read-back of the same word
        add(mk(0, 0, 8'd0, 1, 1, 8'd3, 16'h1421, 0, 0, 1, 0));
        add(mk(0, 0, 8'd0, 1, 0, 8'd3, 16'h0, 0, 0, 1, 0));
        add(mk(0, 0, 8'd0, 0, 0, 8'd0, 16'h0, 0, 0, 0, 0));
        // Contention: host ages in after four CPU grants
        for (int k = 0; k < 4; k++) add(mk(0, 1, 8'(10 + k), 1, 0, 8'd5, 16'h0, 0, 1, 0, 0));
        add(mk(0, 1, 8'd14, 1, 0, 8'd5, 16'h0, 0, 0, 1, 0));
        add(mk(0, 1, 8'd15, 0, 0, 8'd0, 16'h0, 0, 1, 0, 0));
        add(mk(0, 0, 8'd0, 0, 0, 8'd0, 16'h0, 0, 0, 0, 0));
        // Withdrawal after two waits; the count is held, so the retry wins on its third cycle
        add(mk(0, 1, 8'd40, 1, 0, 8'd6, 16'h0, 0, 1, 0, 0));
        add(mk(0, 1, 8'd41, 1, 0, 8'd6, 16'h0, 0, 1, 0, 0));
        add(mk(0, 1, 8'd42, 0, 0, 8'd0, 16'h0, 0, 1, 0, 0));
        add(mk(0, 1, 8'd43, 0, 0, 8'd0, 16'h0, 0, 1, 0, 0));
        add(mk(0, 1, 8'd44, 1, 0, 8'd6, 16'h0, 0, 1, 0, 0));
        add(mk(0, 1, 8'd45, 1, 0, 8'd6, 16'h0, 0, 1, 0, 0));
        add(mk(0, 1, 8'd46, 1, 0, 8'd6, 16'h0, 0, 0, 1, 0));
        add(mk(0, 0, 8'd0, 0, 0, 8'd0, 16'h0, 0, 0, 0, 0));
        // Lock: CPU still wins the edge where lock rises, then is blocked during the download
        add(mk(0, 1, 8'd2, 0, 0, 8'd0, 16'h0, 1, 1, 0, 0));
        for (int k = 0; k < 8; k++)
            add(mk(0, 1, 8'd16, 1, 1, 8'(16 + k), 16'(16'hB000 + k), 1, 0, 1, 1));
        add(mk(0, 1, 8'd16, 0, 0, 8'd0, 16'h0, 0, 0, 0, 1));
        add(mk(0, 1, 8'd16, 0, 0, 8'd0, 16'h0, 0, 1, 0, 0));
        add(mk(0, 1, 8'd23, 0, 0, 8'd0, 16'h0, 0, 1, 0, 0));
        add(mk(0, 0, 8'd0, 0, 0, 8'd0, 16'h0, 0, 0, 0, 0));
        // Reset right after a CPU read grant, with lock requested during reset
        add(mk(0, 1, 8'd7, 0, 0, 8'd0, 16'h0, 0, 1, 0, 0));
        add(mk(1, 1, 8'd7, 1, 0, 8'd9, 16'h0, 1, 0, 0, 0));

        @(posedge clk);
        #1 preload = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
        end

        // After reset the age count restarts: host wins on the 5th contended cycle
        grant_at = -1;
        for (int k = 0; k < 10 && grant_at < 0; k++) begin
            v = mk(0, 1, 8'(32 + k), 1, 0, 8'd9, 16'h0, 0, (k < 4), (k >= 4), 0);
            applyStimulus(v);
            checkOutput(v);
            if (host_gnt) grant_at = k;
        end
        compareVal("age_grant_cycle", 32'(grant_at), 32'd4);
        v = mk(0, 1, 8'd50, 0, 0, 8'd0, 16'h0, 0, 1, 0, 0);
        applyStimulus(v);
        checkOutput(v);
        v = mk(0, 0, 8'd0, 0, 0, 8'd0, 16'h0, 0, 0, 0, 0);
        applyStimulus(v);
        checkOutput(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
